// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencing controller.
package fetch_ctrl_pkg;

  localparam int unsigned WORD      = 64;
  localparam int unsigned INSTR_LEN = 32;

  typedef enum logic [1:0] {
    FC_BOOT  = 2'd0,
    FC_FETCH = 2'd1,
    FC_WAIT  = 2'd2,
    FC_HOLD  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: hazard/branch inputs, imem handshake and fetch datapath controls.
interface fetch_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import fetch_ctrl_pkg::*;

  logic             stall;
  logic             branch_taken;
  logic [WORD-1:0]  branch_target;
  logic             imem_ready;
  logic             imem_req;
  logic             pc_en;
  logic             pc_sel;
  logic [WORD-1:0]  redirect_pc;
  logic             ifid_en;
  logic             ifid_flush;
  logic             instr_valid;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_ready,
    output imem_req, pc_en, pc_sel, redirect_pc, ifid_en, ifid_flush,
           instr_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_ready,
    input  imem_req, pc_en, pc_sel, redirect_pc, ifid_en, ifid_flush,
           instr_valid, fetch_count
  );

endinterface

// File: rtl/fetch_ctrl_redirect_buf.sv
// Holds a branch target that arrived while memory was busy until it can be applied.
module redirect_buf
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [WORD-1:0] d,
  output logic [WORD-1:0] target,
  output logic            pending
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target  <= '0;
      pending <= 1'b0;
    end else if (load) begin
      target  <= d;
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot delay, imem handshake, stall hold and branch redirect.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fc_state_e        state, state_nx;
  logic [3:0]       boot_cnt;
  logic [CNT_W-1:0] fetch_cnt;
  logic             buf_load, buf_clear, cnt_inc;
  logic [WORD-1:0]  buf_target;
  logic             pending;

  redirect_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .d       (bus.branch_target),
    .target  (buf_target),
    .pending (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FC_BOOT;
      boot_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == FC_BOOT) boot_cnt <= boot_cnt + 4'd1;
      if (cnt_inc) fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

  assign bus.fetch_count = fetch_cnt;

  always_comb begin
    state_nx        = state;
    buf_load        = 1'b0;
    buf_clear       = 1'b0;
    cnt_inc         = 1'b0;
    bus.imem_req    = 1'b0;
    bus.pc_en       = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.redirect_pc = bus.branch_taken ? bus.branch_target : buf_target;

    unique case (state)
      FC_BOOT: begin
        bus.redirect_pc = '0;
        if (boot_cnt == BOOT_LAST) state_nx = FC_FETCH;
      end
      // FETCH and WAIT share resolution; a branch seen before the data returns is buffered.
      FC_FETCH, FC_WAIT: begin
        bus.imem_req = 1'b1;
        if (!bus.imem_ready) begin
          state_nx = FC_WAIT;
          buf_load = bus.branch_taken;
        end else if (bus.branch_taken || pending) begin
          bus.pc_en      = 1'b1;
          bus.pc_sel     = 1'b1;
          bus.ifid_en    = 1'b1;
          bus.ifid_flush = 1'b1;
          buf_clear      = 1'b1;
          state_nx       = FC_FETCH;
        end else if (bus.stall) begin
          state_nx = FC_HOLD;
        end else begin
          bus.pc_en       = 1'b1;
          bus.ifid_en     = 1'b1;
          bus.instr_valid = 1'b1;
          cnt_inc         = 1'b1;
          state_nx        = FC_FETCH;
        end
      end
      FC_HOLD: begin
        if (bus.branch_taken) begin
          bus.pc_en      = 1'b1;
          bus.pc_sel     = 1'b1;
          bus.ifid_en    = 1'b1;
          bus.ifid_flush = 1'b1;
          buf_clear      = 1'b1;
          state_nx       = FC_FETCH;
        end else if (!bus.stall) begin
          state_nx = FC_FETCH;
        end
      end
      default: state_nx = FC_BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences, random vs model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int BOOT = 2;
  localparam int CW   = 8;

  localparam logic [5:0] IDLE = 6'b000000;  // {req,pc_en,pc_sel,ifid_en,flush,valid}
  localparam logic [5:0] REQ  = 6'b100000;
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] RDR  = 6'b111110;
  localparam logic [5:0] HRDR = 6'b011110;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_ctrl_if #(.CNT_W(CW)) bus ();

  fetch_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]      flags;
    logic [WORD-1:0] rpc;
    logic [CW-1:0]   cnt;
  } obs_t;

  typedef struct {
    logic            st;
    logic            bt;
    logic [WORD-1:0] tgt;
    logic            rdy;
    obs_t            exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: fetch is either booting, frozen by a stall, or actively requesting.
  int              boot_left;
  bit              frozen;
  bit              pend;
  logic [WORD-1:0] mbuf;
  logic [CW-1:0]   mcnt;

  function automatic vec_t mk(logic st, logic bt, logic [WORD-1:0] tgt, logic rdy,
                              logic [5:0] f, logic [WORD-1:0] rpc, logic [CW-1:0] cnt);
    vec_t v;
    v.st = st; v.bt = bt; v.tgt = tgt; v.rdy = rdy;
    v.exp = {f, rpc, cnt};
    return v;
  endfunction

  function automatic obs_t dut_obs();
    return {bus.imem_req, bus.pc_en, bus.pc_sel, bus.ifid_en, bus.ifid_flush,
            bus.instr_valid, bus.redirect_pc, bus.fetch_count};
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got flags=%b rpc=%h cnt=%0d, expected flags=%b rpc=%h cnt=%0d",
               name, a.flags, a.rpc, a.cnt, e.flags, e.rpc, e.cnt);
    end
  endtask

  task automatic model_step(input logic st, input logic bt, input logic [WORD-1:0] tgt,
                            input logic rdy, output obs_t e);
    logic [5:0] f;
    f = IDLE;
    if (!reset) begin
      boot_left = BOOT; frozen = 0; pend = 0; mbuf = '0; mcnt = '0;
      e = '0;
      return;
    end
    if (boot_left > 0) begin
      boot_left--;
      e = '0;
      e.cnt = mcnt;
      return;
    end
    e.cnt = mcnt;
    e.rpc = bt ? tgt : mbuf;
    if (frozen) begin
      if (bt) begin
        f = HRDR; pend = 0; frozen = 0;
      end else if (!st) begin
        frozen = 0;
      end
    end else begin
      f = REQ;
      if (rdy) begin
        if (bt || pend) begin
          f = RDR; pend = 0;
        end else if (st) begin
          frozen = 1;
        end else begin
          f = NORM; mcnt = mcnt + 1'b1;
        end
      end else if (bt) begin
        mbuf = tgt; pend = 1;
      end
    end
    e.flags = f;
  endtask

  // Called just after a falling edge; inputs settle, outputs are checked, then one clock passes.
  task automatic step(input logic st, input logic bt, input logic [WORD-1:0] tgt,
                      input logic rdy, input bit use_exp, input obs_t texp, input string name);
    obs_t e, a;
    bus.stall = st; bus.branch_taken = bt; bus.branch_target = tgt; bus.imem_ready = rdy;
    #1;
    model_step(st, bt, tgt, rdy, e);
    a = dut_obs();
    check({name, "_model"}, a, e);
    if (use_exp) check(name, a, texp);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    obs_t zero;
    zero = '0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0; bus.imem_ready = 0;

    // boot, throughput, WAIT branch, FETCH branch, HOLD, branch+stall, stall release, wait states
    tbl.push_back(mk(0, 0, 64'h0,    1, IDLE, 64'h0,    8'd0));
    tbl.push_back(mk(0, 0, 64'h0,    1, IDLE, 64'h0,    8'd0));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h0,    8'd0));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h0,    8'd1));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h0,    8'd2));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h0,    8'd3));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h0,    8'd4));
    tbl.push_back(mk(0, 0, 64'h0,    0, REQ,  64'h0,    8'd5));
    tbl.push_back(mk(0, 1, 64'h800,  0, REQ,  64'h800,  8'd5));
    tbl.push_back(mk(0, 0, 64'h0,    1, RDR,  64'h800,  8'd5));
    tbl.push_back(mk(0, 1, 64'h400,  1, RDR,  64'h400,  8'd5));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h800,  8'd5));
    tbl.push_back(mk(1, 0, 64'h0,    1, REQ,  64'h800,  8'd6));
    tbl.push_back(mk(1, 0, 64'h0,    0, IDLE, 64'h800,  8'd6));
    tbl.push_back(mk(1, 0, 64'h0,    1, IDLE, 64'h800,  8'd6));
    tbl.push_back(mk(1, 1, 64'h1000, 0, HRDR, 64'h1000, 8'd6));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h800,  8'd6));
    tbl.push_back(mk(1, 1, 64'h2000, 1, RDR,  64'h2000, 8'd7));
    tbl.push_back(mk(0, 0, 64'h0,    0, REQ,  64'h800,  8'd7));
    tbl.push_back(mk(0, 0, 64'h0,    0, REQ,  64'h800,  8'd7));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h800,  8'd7));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h800,  8'd8));
    tbl.push_back(mk(1, 0, 64'h0,    0, REQ,  64'h800,  8'd9));
    tbl.push_back(mk(1, 0, 64'h0,    1, REQ,  64'h800,  8'd9));
    tbl.push_back(mk(0, 0, 64'h0,    0, IDLE, 64'h800,  8'd9));
    tbl.push_back(mk(0, 0, 64'h0,    1, NORM, 64'h800,  8'd9));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 0, 64'h0, 0, REQ,  64'h800, CW'(10 + k)));
      tbl.push_back(mk(0, 0, 64'h0, 0, REQ,  64'h800, CW'(10 + k)));
      tbl.push_back(mk(0, 0, 64'h0, 1, NORM, 64'h800, CW'(10 + k)));
    end
    tbl.push_back(mk(0, 0, 64'h0, 0, REQ, 64'h800, 8'd13));

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1, zero, "reset_state");
    reset = 1'b1;
    foreach (tbl[i])
      step(tbl[i].st, tbl[i].bt, tbl[i].tgt, tbl[i].rdy, 1, tbl[i].exp, $sformatf("vec%0d", i));

    // Asynchronous reset while waiting on memory with a redirect pending.
    step(0, 1, 64'hABC, 0, 0, zero, "wait_pending");
    #2 reset = 1'b0;
    #1 check("async_reset", dut_obs(), zero);
    @(negedge clk);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 1, zero, "held_reset");
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 1, zero, "reboot");
    step(0, 0, '0, 1, 1, {NORM, 64'h0, 8'd0}, "resume_no_redirect");

    for (int i = 0; i < 1500; i++) begin
      logic [WORD-1:0] t;
      t = {$urandom, $urandom};
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), t,
           ($urandom_range(0, 4) < 3), 0, zero, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
